// File: rtl/arp_req_arb.sv
// Arbiter that lets S_COUNT requesters share one ARP request/response port.
// It runs one transaction at a time and can time out a response, discarding it when it arrives late.
module arp_req_arb #(
  parameter int    S_COUNT          = 4,
  parameter string ARB_TYPE         = "ROUND_ROBIN",
  parameter int    RESPONSE_TIMEOUT = 0,
  parameter int    CL_S_COUNT       = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_COUNT-1:0]      s_arp_request_valid,
  output logic [S_COUNT-1:0]      s_arp_request_ready,
  input  logic [S_COUNT*32-1:0]   s_arp_request_ip,
  output logic [S_COUNT-1:0]      s_arp_response_valid,
  input  logic [S_COUNT-1:0]      s_arp_response_ready,
  output logic [S_COUNT-1:0]      s_arp_response_error,
  output logic [S_COUNT*48-1:0]   s_arp_response_mac,
  output logic                    m_arp_request_valid,
  input  logic                    m_arp_request_ready,
  output logic [31:0]             m_arp_request_ip,
  input  logic                    m_arp_response_valid,
  output logic                    m_arp_response_ready,
  input  logic                    m_arp_response_error,
  input  logic [47:0]             m_arp_response_mac,
  output logic                    busy,
  output logic [CL_S_COUNT-1:0]   grant_index,
  output logic                    timeout_error
);

  localparam bit PRIO = (ARB_TYPE == "PRIORITY");
  localparam int CNT_W = (RESPONSE_TIMEOUT > 1) ? $clog2(RESPONSE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((RESPONSE_TIMEOUT > 0) ? RESPONSE_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_RESP, RESPOND} state_t;

  state_t                 state, state_nxt;
  logic [CL_S_COUNT-1:0]  last_grant;
  logic [CL_S_COUNT-1:0]  sel;
  logic [31:0]            ip_reg;
  logic                   err_reg;
  logic [47:0]            mac_reg;
  logic                   drain_pending;
  logic [CNT_W-1:0]       cnt;
  logic                   any_req;
  logic                   to_fire;
  logic                   m_req_hs;

  assign any_req  = |s_arp_request_valid;
  assign m_req_hs = m_arp_request_valid && m_arp_request_ready;
  assign to_fire  = (RESPONSE_TIMEOUT != 0) && (state == WAIT_RESP) &&
                    !m_arp_response_valid && (cnt == TO_LAST);

  // Later loop iterations overwrite earlier ones, so scanning backwards leaves the winner in sel.
  always_comb begin
    int j;
    sel = '0;
    j   = 0;
    if (PRIO) begin
      for (int i = S_COUNT - 1; i >= 0; i--)
        if (s_arp_request_valid[i]) sel = CL_S_COUNT'(i);
    end else begin
      for (int k = S_COUNT; k >= 1; k--) begin
        j = (int'(last_grant) + k) % S_COUNT;
        if (s_arp_request_valid[j]) sel = CL_S_COUNT'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (any_req) state_nxt = REQUEST;
      REQUEST:   if (m_req_hs) state_nxt = WAIT_RESP;
      WAIT_RESP: if (m_arp_response_valid || to_fire) state_nxt = RESPOND;
      RESPOND:   if (s_arp_response_ready[grant_index]) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= CL_S_COUNT'(S_COUNT - 1);
      grant_index   <= '0;
      ip_reg        <= '0;
      err_reg       <= 1'b0;
      mac_reg       <= '0;
      drain_pending <= 1'b0;
      cnt           <= '0;
    end else begin
      state <= state_nxt;
      // The late beat is consumed wherever it lands; WAIT_RESP never overlaps a drain.
      if (drain_pending && m_arp_response_valid) drain_pending <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          grant_index <= sel;
          ip_reg      <= s_arp_request_ip[32*int'(sel) +: 32];
        end
        REQUEST: if (m_req_hs) cnt <= '0;
        WAIT_RESP: begin
          if (m_arp_response_valid) begin
            err_reg <= m_arp_response_error;
            mac_reg <= m_arp_response_mac;
          end else if (to_fire) begin
            err_reg       <= 1'b1;
            mac_reg       <= '0;
            drain_pending <= 1'b1;
          end else if (RESPONSE_TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESPOND: if (s_arp_response_ready[grant_index]) last_grant <= grant_index;
        default: ;
      endcase
    end
  end

  assign s_arp_request_ready  = (state == IDLE && any_req && !rst) ?
                                (S_COUNT'(1) << sel) : '0;
  assign s_arp_response_valid = (state == RESPOND) ? (S_COUNT'(1) << grant_index) : '0;
  assign s_arp_response_error = {S_COUNT{err_reg}};
  assign s_arp_response_mac   = {S_COUNT{mac_reg}};
  assign m_arp_request_valid  = (state == REQUEST) && !drain_pending;
  assign m_arp_request_ip     = ip_reg;
  assign m_arp_response_ready = (state == WAIT_RESP) || drain_pending;
  assign busy                 = (state != IDLE);
  assign timeout_error        = to_fire;

endmodule

// File: tb/tb_arp_req_arb.sv
// Directed bench for arp_req_arb: a round-robin instance with a 16-cycle timeout and
// a priority instance, both driven by the same stimulus.
module tb_arp_req_arb;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req_valid, resp_ready;
  logic [N*32-1:0] req_ip;
  logic            m_req_ready, m_resp_valid, m_resp_err;
  logic [47:0]     m_resp_mac;

  logic [N-1:0]    rr_req_ready, rr_resp_valid, rr_resp_err;
  logic [N*48-1:0] rr_resp_mac;
  logic            rr_m_req_valid, rr_m_resp_ready, rr_busy, rr_to;
  logic [31:0]     rr_m_ip;
  logic [1:0]      rr_gi;

  logic [N-1:0]    pr_req_ready, pr_resp_valid, pr_resp_err;
  logic [N*48-1:0] pr_resp_mac;
  logic            pr_m_req_valid, pr_m_resp_ready, pr_busy, pr_to;
  logic [31:0]     pr_m_ip;
  logic [1:0]      pr_gi;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  arp_req_arb #(.S_COUNT(N), .ARB_TYPE("ROUND_ROBIN"), .RESPONSE_TIMEOUT(16)) u_rr (
    .clk(clk), .rst(rst),
    .s_arp_request_valid(req_valid), .s_arp_request_ready(rr_req_ready),
    .s_arp_request_ip(req_ip),
    .s_arp_response_valid(rr_resp_valid), .s_arp_response_ready(resp_ready),
    .s_arp_response_error(rr_resp_err), .s_arp_response_mac(rr_resp_mac),
    .m_arp_request_valid(rr_m_req_valid), .m_arp_request_ready(m_req_ready),
    .m_arp_request_ip(rr_m_ip),
    .m_arp_response_valid(m_resp_valid), .m_arp_response_ready(rr_m_resp_ready),
    .m_arp_response_error(m_resp_err), .m_arp_response_mac(m_resp_mac),
    .busy(rr_busy), .grant_index(rr_gi), .timeout_error(rr_to)
  );

  arp_req_arb #(.S_COUNT(N), .ARB_TYPE("PRIORITY"), .RESPONSE_TIMEOUT(0)) u_pr (
    .clk(clk), .rst(rst),
    .s_arp_request_valid(req_valid), .s_arp_request_ready(pr_req_ready),
    .s_arp_request_ip(req_ip),
    .s_arp_response_valid(pr_resp_valid), .s_arp_response_ready(resp_ready),
    .s_arp_response_error(pr_resp_err), .s_arp_response_mac(pr_resp_mac),
    .m_arp_request_valid(pr_m_req_valid), .m_arp_request_ready(m_req_ready),
    .m_arp_request_ip(pr_m_ip),
    .m_arp_response_valid(m_resp_valid), .m_arp_response_ready(pr_m_resp_ready),
    .m_arp_response_error(m_resp_err), .m_arp_response_mac(m_resp_mac),
    .busy(pr_busy), .grant_index(pr_gi), .timeout_error(pr_to)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_reset();
    req_valid    = '0;
    resp_ready   = '0;
    m_req_ready  = 1'b0;
    m_resp_valid = 1'b0;
    m_resp_err   = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [N-1:0] e;
    req_valid    = '0;
    resp_ready   = '0;
    req_ip       = {32'h0A000004, 32'hC0A80101, 32'h0A000002, 32'h0A000001};
    m_req_ready  = 1'b0;
    m_resp_valid = 1'b0;
    m_resp_err   = 1'b0;
    m_resp_mac   = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_busy", {pr_busy, rr_busy}, 2'b00);
    chk("rst_mvalid", {pr_m_req_valid, rr_m_req_valid}, 2'b00);
    chk("rst_mrdy", {pr_m_resp_ready, rr_m_resp_ready}, 2'b00);
    chk("rst_rvalid", rr_resp_valid, 4'h0);
    chk("rst_gi", rr_gi, 2'd0);
    chk("rst_to", {pr_to, rr_to}, 2'b00);

    // single request on lane 2, accepted after 3 cycles, answered 5 cycles later
    req_valid = 4'b0100;
    #1;
    chk("t1_sready", rr_req_ready, 4'b0100);
    step();
    req_valid = '0;
    req_ip[95:64] = 32'hDEADBEEF;
    #1;
    chk("t1_sready_pulse", rr_req_ready, 4'b0000);
    chk("t1_mvalid", rr_m_req_valid, 1'b1);
    chk("t1_mip", rr_m_ip, 32'hC0A80101);
    chk("t1_gi", rr_gi, 2'd2);
    chk("t1_busy", rr_busy, 1'b1);
    step();
    step();
    m_req_ready = 1'b1;
    #1;
    chk("t1_mvalid_held", rr_m_req_valid, 1'b1);
    chk("t1_mip_held", rr_m_ip, 32'hC0A80101);
    step();
    m_req_ready = 1'b0;
    #1;
    chk("t1_mvalid_off", rr_m_req_valid, 1'b0);
    chk("t1_mrdy", rr_m_resp_ready, 1'b1);
    repeat (4) step();
    m_resp_valid = 1'b1;
    m_resp_mac   = 48'h001122334455;
    m_resp_err   = 1'b0;
    step();
    m_resp_valid = 1'b0;
    #1;
    chk("t1_rvalid", rr_resp_valid, 4'b0100);
    chk("t1_mac", rr_resp_mac[2*48 +: 48], 48'h001122334455);
    chk("t1_err", rr_resp_err[2], 1'b0);
    chk("t1_mrdy_off", rr_m_resp_ready, 1'b0);
    resp_ready = 4'b0100;
    step();
    resp_ready = '0;
    #1;
    chk("t1_idle", rr_busy, 1'b0);
    chk("t1_rvalid_off", rr_resp_valid, 4'b0000);

    // all lanes request continuously, ARP answers immediately
    quiet_reset();
    req_valid    = 4'hF;
    m_req_ready  = 1'b1;
    m_resp_valid = 1'b1;
    m_resp_mac   = 48'h0000AABBCCDD;
    resp_ready   = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      chk("t2_idle_gap", rr_busy, 1'b0);
      chk("t2_rr_grant", rr_req_ready, e);
      chk("t2_pr_grant", pr_req_ready, 4'b0001);
      step();
      step();
      step();
      chk("t2_rr_resp", rr_resp_valid, e);
      chk("t2_pr_resp", pr_resp_valid, 4'b0001);
      step();
    end

    // timeout, then a late response drained before lane 1 goes out
    quiet_reset();
    req_valid = 4'b0001;
    #1;
    chk("t3_grant0", rr_req_ready, 4'b0001);
    step();
    req_valid   = '0;
    m_req_ready = 1'b1;
    step();
    m_req_ready = 1'b0;
    #1;
    for (int c = 1; c < 16; c++) begin
      chk("t3_no_timeout", rr_to, 1'b0);
      step();
    end
    chk("t3_timeout", rr_to, 1'b1);
    step();
    chk("t3_rvalid", rr_resp_valid, 4'b0001);
    chk("t3_err", rr_resp_err[0], 1'b1);
    chk("t3_mac", rr_resp_mac[47:0], 48'h0);
    chk("t3_to_pulse", rr_to, 1'b0);
    chk("t3_drain_rdy", rr_m_resp_ready, 1'b1);
    resp_ready = 4'b0001;
    req_valid  = 4'b0010;
    req_ip[63:32] = 32'h0A0000AA;
    step();
    resp_ready = '0;
    #1;
    chk("t3_grant1", rr_req_ready, 4'b0010);
    step();
    req_valid = '0;
    #1;
    chk("t3_hold_req", rr_m_req_valid, 1'b0);
    step();
    chk("t3_hold_req2", rr_m_req_valid, 1'b0);
    m_resp_valid = 1'b1;
    m_resp_mac   = 48'hFFEEDDCCBBAA;
    #1;
    chk("t3_drain_rdy2", rr_m_resp_ready, 1'b1);
    chk("t3_no_fwd", rr_resp_valid, 4'b0000);
    step();
    m_resp_valid = 1'b0;
    #1;
    chk("t3_req_after", rr_m_req_valid, 1'b1);
    chk("t3_req_ip", rr_m_ip, 32'h0A0000AA);
    chk("t3_drain_done", rr_m_resp_ready, 1'b0);
    chk("t3_no_fwd2", rr_resp_valid, 4'b0000);

    // error response passes through without a timeout
    quiet_reset();
    req_valid    = 4'b1000;
    m_req_ready  = 1'b1;
    m_resp_valid = 1'b1;
    m_resp_err   = 1'b1;
    m_resp_mac   = 48'hA1B2C3D4E5F6;
    #1;
    chk("t4_grant3", rr_req_ready, 4'b1000);
    step();
    step();
    chk("t4_no_to", rr_to, 1'b0);
    step();
    chk("t4_rvalid", rr_resp_valid, 4'b1000);
    chk("t4_err", rr_resp_err[3], 1'b1);
    chk("t4_mac", rr_resp_mac[3*48 +: 48], 48'hA1B2C3D4E5F6);
    chk("t4_gi", rr_gi, 2'd3);
    chk("t4_to", rr_to, 1'b0);

    // reset while in RESPOND with the response never taken
    req_valid    = '0;
    m_req_ready  = 1'b0;
    m_resp_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t5a_busy", rr_busy, 1'b0);
    chk("t5a_rvalid", rr_resp_valid, 4'b0000);
    chk("t5a_err", rr_resp_err, 4'b0000);
    chk("t5a_gi", rr_gi, 2'd0);

    // reset while in WAIT_RESP
    req_valid   = 4'b1000;
    m_req_ready = 1'b1;
    step();
    step();
    req_valid   = '0;
    m_req_ready = 1'b0;
    #1;
    chk("t5b_wait", rr_m_resp_ready, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t5b_busy", rr_busy, 1'b0);
    chk("t5b_mrdy", rr_m_resp_ready, 1'b0);
    chk("t5b_mvalid", rr_m_req_valid, 1'b0);
    chk("t5b_sready", rr_req_ready, 4'b0000);
    req_valid = 4'hF;
    #1;
    chk("t5b_lane0_first", rr_req_ready, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
